// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I-subset core: add, sub, and, or, addi, lw, sw, beq.
// Instructions arrive over a req/ack fetch port that tolerates any latency.
// The register file and a word-addressed data memory live inside the core.
// Every writeback is exposed on Data_out together with a one-cycle wb_valid.
module riscv_multicycle_core #(
    parameter int WIDTH      = 32,
    parameter int NUM_REGS   = 32,
    parameter int DMEM_DEPTH = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [WIDTH-1:0] Data_out,
    output logic             wb_valid,
    output logic             halted
);

    localparam int         RW   = $clog2(NUM_REGS);
    localparam int         AW   = $clog2(DMEM_DEPTH);
    localparam logic [5:0] NREG = 6'(NUM_REGS);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic [WIDTH-1:0] alu_q, alu_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             wb_valid_q, wb_valid_d;
    logic             halted_q, halted_d;
    logic             req_q, req_d;

    logic [WIDTH-1:0] rf_q   [NUM_REGS];
    logic [WIDTH-1:0] dmem_q [DMEM_DEPTH];
    logic             rf_we;
    logic             dmem_we;
    logic [AW-1:0]    dmem_idx;

    // Instruction fields, always taken from the instruction register
    logic [6:0] opcode;
    logic [4:0] rd, rs1, rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    logic is_add, is_sub, is_and, is_or, is_r, is_addi, is_lw, is_sw, is_beq;
    logic rd_ok, rs1_ok, rs2_ok, legal;

    assign is_add  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
    assign is_sub  = (opcode == 7'b0110011) && (funct3 == 3'b000) && (funct7 == 7'b0100000);
    assign is_and  = (opcode == 7'b0110011) && (funct3 == 3'b111) && (funct7 == 7'b0000000);
    assign is_or   = (opcode == 7'b0110011) && (funct3 == 3'b110) && (funct7 == 7'b0000000);
    assign is_r    = is_add || is_sub || is_and || is_or;
    assign is_addi = (opcode == 7'b0010011) && (funct3 == 3'b000);
    assign is_lw   = (opcode == 7'b0000011) && (funct3 == 3'b010);
    assign is_sw   = (opcode == 7'b0100011) && (funct3 == 3'b010);
    assign is_beq  = (opcode == 7'b1100011) && (funct3 == 3'b000);

    // Only the register fields a format actually uses are range-checked;
    // in I/S/B formats the other field positions carry immediate bits.
    assign rd_ok  = ({1'b0, rd}  < NREG);
    assign rs1_ok = ({1'b0, rs1} < NREG);
    assign rs2_ok = ({1'b0, rs2} < NREG);
    assign legal  = (is_r && rd_ok && rs1_ok && rs2_ok)
                 || ((is_addi || is_lw) && rd_ok && rs1_ok)
                 || ((is_sw || is_beq) && rs1_ok && rs2_ok);

    logic [WIDTH-1:0] rs1_val, rs2_val;
    assign rs1_val = rf_q[rs1[RW-1:0]];
    assign rs2_val = rf_q[rs2[RW-1:0]];

    // Immediate assembly: S for stores, B for branches, I otherwise
    logic [31:0]      imm32;
    logic [WIDTH-1:0] imm_ext;
    always_comb begin
        imm32 = {{20{ir_q[31]}}, ir_q[31:20]};
        if (is_sw) begin
            imm32 = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
        end else if (is_beq) begin
            imm32 = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
        end
    end
    assign imm_ext = {{(WIDTH-31){imm32[31]}}, imm32[30:0]};

    // ALU: immediate forms add A+imm, register forms pick the R-type op
    logic [WIDTH-1:0] alu_res;
    always_comb begin
        alu_res = a_q + b_q;
        if (is_addi || is_lw || is_sw) begin
            alu_res = a_q + imm_q;
        end else if (is_sub) begin
            alu_res = a_q - b_q;
        end else if (is_and) begin
            alu_res = a_q & b_q;
        end else if (is_or) begin
            alu_res = a_q | b_q;
        end
    end

    // Word index drops the byte offset; upper address bits wrap away
    assign dmem_idx = alu_q[AW+1:2];

    // Next-state and datapath control; Data_out/wb_valid load on entry to WB
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        a_d        = a_q;
        b_d        = b_q;
        imm_d      = imm_q;
        alu_d      = alu_q;
        data_out_d = data_out_q;
        wb_valid_d = 1'b0;
        halted_d   = halted_q;
        rf_we      = 1'b0;
        dmem_we    = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (req_q && imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                a_d   = rs1_val;
                b_d   = rs2_val;
                imm_d = imm_ext;
                if (legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end
            end
            S_EXEC: begin
                if (is_beq) begin
                    pc_d    = (a_q == b_q) ? (pc_q + imm_q) : (pc_q + WIDTH'(4));
                    state_d = S_FETCH;
                end else if (is_lw || is_sw) begin
                    alu_d   = alu_res;
                    state_d = S_MEM;
                end else begin
                    data_out_d = alu_res;
                    wb_valid_d = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_MEM: begin
                if (is_sw) begin
                    dmem_we = 1'b1;
                    pc_d    = pc_q + WIDTH'(4);
                    state_d = S_FETCH;
                end else begin
                    data_out_d = dmem_q[dmem_idx];
                    wb_valid_d = 1'b1;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                rf_we   = (rd != 5'd0);
                pc_d    = pc_q + WIDTH'(4);
                state_d = S_FETCH;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
        // Request is registered so it is low throughout reset and rises one clock after release
        req_d = (state_d == S_FETCH);
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            pc_q       <= '0;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            imm_q      <= '0;
            alu_q      <= '0;
            data_out_q <= '0;
            wb_valid_q <= 1'b0;
            halted_q   <= 1'b0;
            req_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            b_q        <= b_d;
            imm_q      <= imm_d;
            alu_q      <= alu_d;
            data_out_q <= data_out_d;
            wb_valid_q <= wb_valid_d;
            halted_q   <= halted_d;
            req_q      <= req_d;
        end
    end

    // Register file; x0 is never written so it always reads zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (rf_we) begin
            rf_q[rd[RW-1:0]] <= data_out_q;
        end
    end

    // Data memory, cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DMEM_DEPTH; i++) begin
                dmem_q[i] <= '0;
            end
        end else if (dmem_we) begin
            dmem_q[dmem_idx] <= b_q;
        end
    end

    logic unused_addr_bits;
    assign unused_addr_bits = ^alu_q;

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign Data_out  = data_out_q;
    assign wb_valid  = wb_valid_q;
    assign halted    = halted_q;

endmodule

// File: doc/riscv_multicycle_core.md
Name: riscv_multicycle_core

Overview:
- Parametrised next-generation RISC-V core for this design: multi-cycle FSM core replacing the single-cycle Data_path/Control_Unit pairing.
- Executes an RV32I subset: add, sub, and, or, addi, lw, sw, beq.
- Fetches instructions over a req/ack port that tolerates any memory latency.
- Holds the register file and a word-addressed data memory internally, and exposes writeback data on Data_out with a valid strobe.

Parameters:
- WIDTH, 32, datapath/register/PC width. Legal values are 32 or 64; immediates are sign-extended to WIDTH.
- NUM_REGS, 32, register count. Legal values are 16 (RV32E-style) or 32.
- DMEM_DEPTH, 256, data memory words of WIDTH bits. Must be a power of 2, at least 4.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req  output  1  fetch request. High only in FETCH.
- imem_addr  output  WIDTH  byte address of the fetch; equals PC.
- imem_ack  input  1  fetch data valid. Sampled only while imem_req=1.
- imem_rdata  input  32  instruction word. Captured only on a cycle where imem_req=1 and imem_ack=1.
- Data_out  output  WIDTH  last value written back to the register file.
- wb_valid  output  1  one-cycle pulse when Data_out updates.
- halted  output  1  core stopped on an illegal instruction.

Behaviour:
- Reset is asynchronous, active-low. Asserting it clears:
  - PC, all registers, all DMEM words, the instruction register, Data_out, wb_valid and halted to 0;
  - imem_req to 0;
  - FSM state to FETCH.
- Reset mid-operation abandons any outstanding fetch. After reset releases, imem_req=1 on the first clock with imem_addr=0.
- FSM states: FETCH, DECODE, EXEC, MEM, WB, HALT.
- FETCH:
  - imem_req=1 and imem_addr=PC.
  - Stay in FETCH while imem_ack=0.
  - On ack, latch imem_rdata into IR and go to DECODE. An ack in the first FETCH cycle is legal (zero wait).
- DECODE:
  - Read rs1/rs2 into the A/B registers and build the immediate (I, S or B format).
  - Check legality:
    - opcode/funct3/funct7 must be one of the supported encodings below;
    - rd, rs1 and rs2 must be below NUM_REGS.
  - Illegal → HALT; legal → EXEC.
- EXEC:
  - R-type add/sub/and/or and addi: ALU result → WB.
  - lw/sw: address A+immI or A+immS → MEM.
  - beq:
    - if A==B, PC ← PC+immB (imm bit0=0), otherwise PC ← PC+4;
    - → FETCH. No writeback.
- MEM:
  - DMEM index = addr[log2(DMEM_DEPTH)+1:2]. Address bits [1:0] and bits above the index are ignored, so addresses wrap modulo the memory size.
  - sw: write B, PC ← PC+4, → FETCH.
  - lw: register the read word → WB.
- WB:
  - If rd≠0, write the register file.
  - Data_out ← value and wb_valid=1 for this one cycle. Data_out and wb_valid update even when rd=0.
  - PC ← PC+4, → FETCH.
- HALT: terminal until reset. halted=1, imem_req=0, PC frozen at the illegal instruction's address.
- Register x0 always reads 0.
- Arithmetic wraps modulo 2^WIDTH. The PC also wraps modulo 2^WIDTH.
- Cycle counts with zero-wait fetch:
  - R/I-type: 4 cycles;
  - lw: 5 cycles;
  - sw: 4 cycles;
  - beq: 3 cycles.
  - Each wait cycle in FETCH adds 1.
- Supported encodings:
  - 0110011 with funct3 000/funct7 0000000 (add), 000/0100000 (sub), 111/0000000 (and), 110/0000000 (or);
  - 0010011 with funct3 000 (addi);
  - 0000011 with funct3 010 (lw);
  - 0100011 with funct3 010 (sw);
  - 1100011 with funct3 000 (beq).
- imem_rdata changes while imem_ack=0 must have no effect on the core.

Test Plan:
- Zero-wait program:
  - stimulus: addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2;
  - response: wb_valid pulses with Data_out=5, then 0xFFFFFFFF...FD, then 2; pulses 4 cycles apart; imem_addr sequence 0,4,8.
- Fetch latency:
  - stimulus: imem_ack delayed 3 cycles per fetch on the same program;
  - response: identical Data_out values, pulses 7 cycles apart; IR unaffected by garbage on imem_rdata before ack.
- Memory wrap with DMEM_DEPTH=4:
  - stimulus: sw x1 (value 5) to address 0x10, then lw x4 from 0x0;
  - response: Data_out=5 (index wrap); lw takes 5 cycles.
- Branches:
  - stimulus: beq x1,x1,+8 at PC 0x0C;
  - response: next imem_addr=0x14 with no wb_valid pulse.
  - stimulus: beq with x1≠x2;
  - response: next imem_addr=0x10.
- x0 and illegal instructions:
  - stimulus: addi x0,x0,7;
  - response: Data_out=7 and wb_valid pulses, but x0 still reads 0.
  - stimulus: opcode 0110111 (lui);
  - response: halted=1 after DECODE, imem_req stays 0, PC frozen.
  - stimulus: NUM_REGS=16 with rd=x20;
  - response: halt.
- Reset mid-fetch:
  - stimulus: drop rst_n while imem_req=1 awaiting ack;
  - response: outputs clear asynchronously; after release, fetch restarts at imem_addr=0 and the register file reads all zero.
